// File: rtl/sccb_slave.sv
`timescale 1ns/1ps
// SCCB responder (camera side): oversampled START/STOP/bit decode, 16-bit sub-address pointer, 8-bit data.
// Optional build macro SCCB_SLAVE_ACK_DRIVE_EN makes the slave pull siod low in every ack slot.

module sccb_slave #(
    parameter logic [6:0] DEV_ID      = 7'h3C,
    parameter int         SYNC_STAGES = 2
) (
    input  logic        sys_clk,
    input  logic        sys_rst,
    input  logic        sccb_sioc,
    inout  wire         sccb_siod,
    output logic        reg_wr_en,
    output logic [15:0] reg_wr_addr,
    output logic [7:0]  reg_wr_data,
    output logic        reg_rd_en,
    output logic [15:0] reg_rd_addr,
    input  logic [7:0]  reg_rd_data,
    output logic        busy
);

`ifdef SCCB_SLAVE_ACK_DRIVE_EN
    localparam logic ACK_DRIVE = 1'b1;
`else
    localparam logic ACK_DRIVE = 1'b0;
`endif

    typedef enum logic [3:0] {
        ST_IDLE      = 4'd0,
        ST_ID        = 4'd1,
        ST_ID_ACK    = 4'd2,
        ST_SUBH      = 4'd3,
        ST_SUBH_ACK  = 4'd4,
        ST_SUBL      = 4'd5,
        ST_SUBL_ACK  = 4'd6,
        ST_WDATA     = 4'd7,
        ST_WDATA_ACK = 4'd8,
        ST_RDATA     = 4'd9,
        ST_RD_NA     = 4'd10,
        ST_WAIT_STOP = 4'd11
    } state_e;

    logic [SYNC_STAGES-1:0] sioc_sync_q, siod_sync_q;
    logic        sioc_prev_q, siod_prev_q;
    logic        sioc_s, siod_s;
    logic        sioc_rise_s, sioc_fall_s, start_s, stop_s;
    logic [7:0]  byte_s;

    state_e      state_q, state_d, ack_state_s, post_ack_s;
    logic [2:0]  bit_cnt_q, bit_cnt_d;
    logic [6:0]  shift_q, shift_d;
    logic [15:0] ptr_q, ptr_d;
    logic        rw_q, rw_d;
    logic        ack_seen_q, ack_seen_d;
    logic        oe_q, oe_d;
    logic [1:0]  rd_wait_q, rd_wait_d;
    logic [6:0]  rd_shift_q, rd_shift_d;
    logic        wr_en_q, wr_en_d;
    logic [15:0] wr_addr_q, wr_addr_d;
    logic [7:0]  wr_data_q, wr_data_d;
    logic        rd_en_q, rd_en_d;
    logic        busy_q, busy_d;

    // Input synchronizers plus one history flop for edge detection; reset to idle-bus levels.
    always_ff @(posedge sys_clk or posedge sys_rst) begin
        if (sys_rst) begin
            sioc_sync_q <= {SYNC_STAGES{1'b1}};
            siod_sync_q <= {SYNC_STAGES{1'b1}};
            sioc_prev_q <= 1'b1;
            siod_prev_q <= 1'b1;
        end else begin
            sioc_sync_q <= {sioc_sync_q[SYNC_STAGES-2:0], sccb_sioc};
            siod_sync_q <= {siod_sync_q[SYNC_STAGES-2:0], sccb_siod};
            sioc_prev_q <= sioc_sync_q[SYNC_STAGES-1];
            siod_prev_q <= siod_sync_q[SYNC_STAGES-1];
        end
    end

    assign sioc_s      = sioc_sync_q[SYNC_STAGES-1];
    assign siod_s      = siod_sync_q[SYNC_STAGES-1];
    assign sioc_rise_s = sioc_s & ~sioc_prev_q;
    assign sioc_fall_s = ~sioc_s & sioc_prev_q;
    assign start_s     = sioc_s & sioc_prev_q & siod_prev_q & ~siod_s;
    assign stop_s      = sioc_s & sioc_prev_q & ~siod_prev_q & siod_s;
    assign byte_s      = {shift_q, siod_s};

    // State and datapath registers.
    always_ff @(posedge sys_clk or posedge sys_rst) begin
        if (sys_rst) begin
            state_q    <= ST_IDLE;
            bit_cnt_q  <= 3'd0;
            shift_q    <= 7'd0;
            ptr_q      <= 16'd0;
            rw_q       <= 1'b0;
            ack_seen_q <= 1'b0;
            oe_q       <= 1'b0;
            rd_wait_q  <= 2'd0;
            rd_shift_q <= 7'd0;
            wr_en_q    <= 1'b0;
            wr_addr_q  <= 16'd0;
            wr_data_q  <= 8'd0;
            rd_en_q    <= 1'b0;
            busy_q     <= 1'b0;
        end else begin
            state_q    <= state_d;
            bit_cnt_q  <= bit_cnt_d;
            shift_q    <= shift_d;
            ptr_q      <= ptr_d;
            rw_q       <= rw_d;
            ack_seen_q <= ack_seen_d;
            oe_q       <= oe_d;
            rd_wait_q  <= rd_wait_d;
            rd_shift_q <= rd_shift_d;
            wr_en_q    <= wr_en_d;
            wr_addr_q  <= wr_addr_d;
            wr_data_q  <= wr_data_d;
            rd_en_q    <= rd_en_d;
            busy_q     <= busy_d;
        end
    end

    // Successor lookup: byte state -> its ack slot, ack slot -> following byte state.
    always_comb begin
        ack_state_s = ST_WDATA_ACK;
        post_ack_s  = ST_WDATA;
        case (state_q)
            ST_ID:       ack_state_s = ST_ID_ACK;
            ST_SUBH:     ack_state_s = ST_SUBH_ACK;
            ST_SUBL:     ack_state_s = ST_SUBL_ACK;
            ST_ID_ACK:   post_ack_s  = rw_q ? ST_RDATA : ST_SUBH;
            ST_SUBH_ACK: post_ack_s  = ST_SUBL;
            default:     post_ack_s  = ST_WDATA;
        endcase
    end

    // Next-state and output logic; STOP and START override every state.
    always_comb begin
        state_d    = state_q;
        bit_cnt_d  = bit_cnt_q;
        shift_d    = shift_q;
        ptr_d      = ptr_q;
        rw_d       = rw_q;
        ack_seen_d = ack_seen_q;
        oe_d       = oe_q;
        rd_wait_d  = rd_wait_q;
        rd_shift_d = rd_shift_q;
        wr_en_d    = 1'b0;
        wr_addr_d  = wr_addr_q;
        wr_data_d  = wr_data_q;
        rd_en_d    = 1'b0;
        busy_d     = busy_q;
        if (stop_s) begin
            state_d   = ST_IDLE;
            oe_d      = 1'b0;
            rd_wait_d = 2'd0;
            busy_d    = 1'b0;
        end else if (start_s) begin
            state_d   = ST_ID;
            bit_cnt_d = 3'd0;
            oe_d      = 1'b0;
            rd_wait_d = 2'd0;
        end else begin
            case (state_q)
                ST_ID, ST_SUBH, ST_SUBL, ST_WDATA: begin
                    if (sioc_rise_s) begin
                        shift_d   = byte_s[6:0];
                        bit_cnt_d = bit_cnt_q + 3'd1;
                        if (bit_cnt_q == 3'd7) begin
                            ack_seen_d = 1'b0;
                            state_d    = ack_state_s;
                            case (state_q)
                                ST_ID: begin
                                    if (byte_s[7:1] == DEV_ID) begin
                                        rw_d   = byte_s[0];
                                        busy_d = 1'b1;
                                    end else begin
                                        state_d = ST_WAIT_STOP;
                                        busy_d  = 1'b0;
                                    end
                                end
                                ST_SUBH: ptr_d[15:8] = byte_s;
                                ST_SUBL: ptr_d[7:0]  = byte_s;
                                default: begin
                                    wr_en_d   = 1'b1;
                                    wr_addr_d = ptr_q;
                                    wr_data_d = byte_s;
                                    ptr_d     = ptr_q + 16'd1;
                                end
                            endcase
                        end else begin
                            state_d = state_q;
                        end
                    end else begin
                        state_d = state_q;
                    end
                end
                ST_ID_ACK, ST_SUBH_ACK, ST_SUBL_ACK, ST_WDATA_ACK: begin
                    if (sioc_rise_s) begin
                        ack_seen_d = 1'b1;
                    end else if (sioc_fall_s && ack_seen_q) begin
                        oe_d      = 1'b0;
                        state_d   = post_ack_s;
                        bit_cnt_d = 3'd0;
                        if ((state_q == ST_ID_ACK) && rw_q) begin
                            rd_en_d   = 1'b1;
                            rd_wait_d = 2'd2;
                        end else begin
                            rd_wait_d = 2'd0;
                        end
                    end else if (sioc_fall_s) begin
                        oe_d = ACK_DRIVE;
                    end else begin
                        oe_d = oe_q;
                    end
                end
                ST_RDATA: begin
                    // Read data appears two cycles after the request; the first bit goes out in the same low phase.
                    if (rd_wait_q != 2'd0) begin
                        rd_wait_d = rd_wait_q - 2'd1;
                        if (rd_wait_q == 2'd1) begin
                            rd_shift_d = reg_rd_data[6:0];
                            oe_d       = ~reg_rd_data[7];
                        end else begin
                            oe_d = 1'b0;
                        end
                    end else if (sioc_rise_s) begin
                        bit_cnt_d = bit_cnt_q + 3'd1;
                        state_d   = (bit_cnt_q == 3'd7) ? ST_RD_NA : ST_RDATA;
                    end else if (sioc_fall_s) begin
                        oe_d       = ~rd_shift_q[6];
                        rd_shift_d = {rd_shift_q[5:0], 1'b0};
                    end else begin
                        oe_d = oe_q;
                    end
                end
                ST_RD_NA: begin
                    if (sioc_fall_s) begin
                        oe_d    = 1'b0;
                        state_d = ST_WAIT_STOP;
                    end else begin
                        state_d = ST_RD_NA;
                    end
                end
                default: begin
                    state_d = state_q;
                end
            endcase
        end
    end

    assign sccb_siod   = oe_q ? 1'b0 : 1'bz;
    assign reg_wr_en   = wr_en_q;
    assign reg_wr_addr = wr_addr_q;
    assign reg_wr_data = wr_data_q;
    assign reg_rd_en   = rd_en_q;
    assign reg_rd_addr = ptr_q;
    assign busy        = busy_q;

endmodule

// File: tb/tb_sccb_slave.sv
`timescale 1ns/1ps
// Bench for sccb_slave: bit-banged SCCB master, transaction-level pointer model, strobe scoreboard.

module tb_sccb_slave;

    localparam int Q = 60;
    localparam int H = 120;
`ifdef SCCB_SLAVE_ACK_DRIVE_EN
    localparam logic ACK_EXP = 1'b0;
`else
    localparam logic ACK_EXP = 1'b1;
`endif

    logic        sys_clk  = 1'b0;
    logic        sys_rst  = 1'b1;
    logic        sioc     = 1'b1;
    logic        siod_low = 1'b0;
    wire         sccb_siod;
    logic        reg_wr_en, reg_rd_en, busy;
    logic [15:0] reg_wr_addr, reg_rd_addr;
    logic [7:0]  reg_wr_data, reg_rd_data;

    int          checks = 0;
    int          errors = 0;
    int          busy_cycles = 0;
    logic [23:0] exp_wr_q[$];
    logic [15:0] exp_rd_q[$];
    logic [15:0] ptr_m = 16'h0000;

    pullup (sccb_siod);
    assign sccb_siod = siod_low ? 1'b0 : 1'bz;

    always #5 sys_clk = ~sys_clk;

    function automatic logic [7:0] rd_val(input logic [15:0] a);
        return a[7:0] ^ a[15:8] ^ 8'h6C;
    endfunction

    assign reg_rd_data = rd_val(reg_rd_addr);

    sccb_slave dut (
        .sys_clk    (sys_clk),
        .sys_rst    (sys_rst),
        .sccb_sioc  (sioc),
        .sccb_siod  (sccb_siod),
        .reg_wr_en  (reg_wr_en),
        .reg_wr_addr(reg_wr_addr),
        .reg_wr_data(reg_wr_data),
        .reg_rd_en  (reg_rd_en),
        .reg_rd_addr(reg_rd_addr),
        .reg_rd_data(reg_rd_data),
        .busy       (busy)
    );

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h, expected %0h", name, act, exp);
        end
    endtask

    task automatic put_bit(input logic b);
        siod_low = ~b;
        #Q sioc = 1'b1;
        #H sioc = 1'b0;
        #Q;
    endtask

    task automatic get_bit(output logic b);
        siod_low = 1'b0;
        #Q sioc = 1'b1;
        #(H/2) b = (sccb_siod !== 1'b0);
        #(H/2) sioc = 1'b0;
        #Q;
    endtask

    task automatic put_bits(input logic [7:0] v, input int n);
        for (int i = 0; i < n; i++) put_bit(v[7-i]);
    endtask

    task automatic send_byte(input logic [7:0] v, input logic exp_ack, input string name);
        logic a;
        put_bits(v, 8);
        get_bit(a);
        check(name, a, exp_ack);
    endtask

    task automatic bus_start();
        siod_low = 1'b0;
        #Q sioc = 1'b1;
        #H siod_low = 1'b1;
        #H sioc = 1'b0;
        #Q;
    endtask

    task automatic bus_stop();
        siod_low = 1'b1;
        #Q sioc = 1'b1;
        #H siod_low = 1'b0;
        #H;
    endtask

    // Write transaction: ID, then n bytes (sub-address high, low, data...).
    task automatic wr_txn(input logic [7:0] id, input logic [7:0] b [8], input int n);
        logic match;
        match = (id == 8'h78);
        if (match) begin
            for (int i = 0; i < n; i++) begin
                if (i == 0) ptr_m[15:8] = b[i];
                else if (i == 1) ptr_m[7:0] = b[i];
                else begin
                    exp_wr_q.push_back({ptr_m, b[i]});
                    ptr_m = ptr_m + 16'd1;
                end
            end
        end
        bus_start();
        send_byte(id, match ? ACK_EXP : 1'b1, "id_ack");
        check("busy_after_id", busy, match);
        for (int i = 0; i < n; i++) send_byte(b[i], match ? ACK_EXP : 1'b1, "byte_ack");
        bus_stop();
        check("busy_after_stop", busy, 1'b0);
    endtask

    task automatic rd_txn();
        logic [7:0] v;
        logic       bt;
        exp_rd_q.push_back(ptr_m);
        bus_start();
        send_byte(8'h79, ACK_EXP, "rd_id_ack");
        check("busy_in_read", busy, 1'b1);
        for (int i = 0; i < 8; i++) begin
            get_bit(bt);
            v = {v[6:0], bt};
        end
        check("rd_byte", v, rd_val(ptr_m));
        put_bit(1'b1);
        bus_stop();
        check("busy_after_rd_stop", busy, 1'b0);
    endtask

    initial begin
        #3000000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        int          bc0, k, n;
        logic [15:0] a;
        logic [7:0]  b [8];
        logic [23:0] ew;
        logic [15:0] er;

        // Scoreboard monitor: pops one expectation per strobe observed.
        fork
            forever begin
                @(negedge sys_clk);
                if (busy) busy_cycles++;
                if (reg_wr_en) begin
                    if (exp_wr_q.size() == 0) begin
                        checks++; errors++;
                        $display("FAIL unexpected_wr: addr %h data %h, no strobe expected", reg_wr_addr, reg_wr_data);
                    end else begin
                        ew = exp_wr_q.pop_front();
                        check("wr_strobe", {reg_rd_en, reg_wr_addr, reg_wr_data}, {1'b0, ew});
                    end
                end
                if (reg_rd_en) begin
                    if (exp_rd_q.size() == 0) begin
                        checks++; errors++;
                        $display("FAIL unexpected_rd: addr %h, no strobe expected", reg_rd_addr);
                    end else begin
                        er = exp_rd_q.pop_front();
                        check("rd_strobe", {reg_wr_en, reg_rd_addr}, {1'b0, er});
                    end
                end
            end
        join_none

        repeat (5) @(posedge sys_clk);
        #1;
        check("reset_outputs", {reg_wr_en, reg_rd_en, busy, reg_wr_addr, reg_wr_data, reg_rd_addr}, 64'd0);
        check("reset_siod", sccb_siod, 1'b1);
        @(negedge sys_clk) sys_rst = 1'b0;
        repeat (5) @(posedge sys_clk);

        wr_txn(8'h78, '{8'h30, 8'h08, 8'h82, 8'h00, 8'h00, 8'h00, 8'h00, 8'h00}, 3);

        bc0 = busy_cycles;
        wr_txn(8'h42, '{8'h11, 8'h22, 8'h33, 8'h00, 8'h00, 8'h00, 8'h00, 8'h00}, 3);
        check("mismatch_busy_cycles", busy_cycles - bc0, 0);

        wr_txn(8'h78, '{8'h30, 8'h0A, 8'h00, 8'h00, 8'h00, 8'h00, 8'h00, 8'h00}, 2);
        rd_txn();

        // STOP four bits into a data byte.
        bus_start();
        send_byte(8'h78, ACK_EXP, "id_ack");
        send_byte(8'h12, ACK_EXP, "byte_ack");
        send_byte(8'h34, ACK_EXP, "byte_ack");
        ptr_m = 16'h1234;
        put_bits(8'hA5, 4);
        bus_stop();
        check("busy_after_partial_stop", busy, 1'b0);
        rd_txn();

        // Repeated START three bits into the low sub-address byte.
        bus_start();
        send_byte(8'h78, ACK_EXP, "id_ack");
        send_byte(8'h56, ACK_EXP, "byte_ack");
        ptr_m[15:8] = 8'h56;
        put_bits(8'h78, 3);
        wr_txn(8'h78, '{8'h40, 8'h01, 8'h9C, 8'h3D, 8'h00, 8'h00, 8'h00, 8'h00}, 4);
        rd_txn();

        wr_txn(8'h78, '{8'hFF, 8'hFF, 8'h11, 8'h22, 8'h33, 8'h00, 8'h00, 8'h00}, 5);
        rd_txn();

        // Reset during the sixth bit of a data byte.
        bus_start();
        send_byte(8'h78, ACK_EXP, "id_ack");
        send_byte(8'hAB, ACK_EXP, "byte_ack");
        send_byte(8'hCD, ACK_EXP, "byte_ack");
        put_bits(8'hF0, 5);
        siod_low = 1'b0;
        sys_rst  = 1'b1;
        #1;
        check("midrst_outputs", {reg_wr_en, reg_rd_en, busy, reg_wr_addr, reg_wr_data, reg_rd_addr}, 64'd0);
        check("midrst_siod", sccb_siod, 1'b1);
        ptr_m = 16'h0000;
        repeat (4) @(posedge sys_clk);
        @(negedge sys_clk) sys_rst = 1'b0;
        rd_txn();
        wr_txn(8'h78, '{8'h12, 8'h34, 8'h56, 8'h00, 8'h00, 8'h00, 8'h00, 8'h00}, 3);

        for (int t = 0; t < 12; t++) begin
            k = $urandom_range(0, 2);
            a = 16'($urandom);
            if ($urandom_range(0, 3) == 0) a = 16'hFFFE;
            n = (k == 0) ? 3 + $urandom_range(0, 3) : 2;
            b[0] = a[15:8];
            b[1] = a[7:0];
            for (int i = 2; i < 8; i++) b[i] = 8'($urandom);
            if (k == 2) begin
                rd_txn();
            end else begin
                wr_txn(8'h78, b, n);
                if (k == 1) rd_txn();
            end
        end

        repeat (20) @(posedge sys_clk);
        check("wr_queue_empty", exp_wr_q.size(), 0);
        check("rd_queue_empty", exp_rd_q.size(), 0);
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
